// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding and arithmetic helpers for the SNN layer
package snn_pkg;

  typedef enum logic {INTEGRATE = 1'b0, REFRACT = 1'b1} lif_state_e;

  function automatic int sum_w(input int n, input int w);
    return w + $clog2(n + 1);
  endfunction

  function automatic int sat_clamp(input int x, input int lo, input int hi);
    return x < lo ? lo : x > hi ? hi : x;
  endfunction

endpackage

// File: rtl/syn_weighted_sum.sv
// syn_weighted_sum: combinational sum of the weights whose presynaptic spike is set
import snn_pkg::*;

module syn_weighted_sum #(
  parameter int N_IN    = 25,
  parameter int W_WIDTH = 4,
  parameter int SW      = sum_w(N_IN, W_WIDTH)
) (
  input  logic [N_IN-1:0]         spikes_i,
  input  logic [N_IN*W_WIDTH-1:0] weights_i,
  output logic [SW-1:0]           sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN; i++)
      sum_o = sum_o + (spikes_i[i] ? SW'(weights_i[i*W_WIDTH +: W_WIDTH]) : SW'(0));
  end

endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with clamped membrane, refractory period and spike counter
import snn_pkg::*;

module lif_neuron #(
  parameter int N_IN      = 25,
  parameter int W_WIDTH   = 4,
  parameter int V_WIDTH   = 8,
  parameter int K_WIDTH   = 5,
  parameter int REF_WIDTH = 4,
  parameter int SC_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         spikes_in,
  input  logic [N_IN*W_WIDTH-1:0] weights,
  input  logic [K_WIDTH-1:0]      ksyn,
  input  logic [V_WIDTH-1:0]      vth,
  input  logic [V_WIDTH-1:0]      vrest,
  input  logic [V_WIDTH-1:0]      vleak,
  input  logic [REF_WIDTH-1:0]    t_ref,
  input  logic                    lat_inhibit,
  input  logic                    count_clr,
  output logic [V_WIDTH-1:0]      vmem,
  output logic                    out_spike,
  output logic                    refractory,
  output logic [SC_WIDTH-1:0]     spike_count
);

  localparam int SW = sum_w(N_IN, W_WIDTH);
  localparam int PW = SW + K_WIDTH;
  localparam int CW = V_WIDTH + PW + 1;

  lif_state_e           state_q;
  logic [V_WIDTH-1:0]   vmem_q;
  logic                 spike_q;
  logic [REF_WIDTH-1:0] ref_q;
  logic [SC_WIDTH-1:0]  cnt_q;
  logic [SW-1:0]        syn;
  logic [PW-1:0]        drive;
  logic signed [CW-1:0] vcand;
  logic [V_WIDTH-1:0]   vclamp_d;
  logic                 fire_d;
  logic [SC_WIDTH-1:0]  cnt_d;

  syn_weighted_sum #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .SW(SW)) u_sum (
    .spikes_i  (spikes_in),
    .weights_i (weights),
    .sum_o     (syn)
  );

  // Wide signed candidate so a large leak goes negative instead of wrapping
  always_comb begin
    drive    = PW'(syn) * PW'(ksyn);
    vcand    = $signed(CW'(vmem_q) + CW'(drive) - CW'(vleak));
    vclamp_d = V_WIDTH'(sat_clamp(int'(vcand), int'(vrest), (1 << V_WIDTH) - 1));
    fire_d   = state_q == INTEGRATE && !lat_inhibit && vclamp_d >= vth;
    cnt_d    = count_clr ? '0 : fire_d && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INTEGRATE;
      vmem_q  <= vrest;
      spike_q <= 1'b0;
      ref_q   <= '0;
      cnt_q   <= '0;
    end else begin
      spike_q <= fire_d;
      cnt_q   <= cnt_d;
      vmem_q  <= state_q == INTEGRATE && !lat_inhibit && !fire_d ? vclamp_d : vrest;
      if (state_q == REFRACT) begin
        if (ref_q == '0) state_q <= INTEGRATE;
        else ref_q <= ref_q - 1'b1;
      end else if (fire_d && t_ref != '0) begin
        state_q <= REFRACT;
        ref_q   <= t_ref - 1'b1;
      end
    end
  end

  assign vmem        = vmem_q;
  assign out_spike   = spike_q;
  assign refractory  = state_q == REFRACT;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed and random stimulus against an integer reference model of the neuron
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] spikes_in;
  logic [99:0] weights;
  logic [4:0]  ksyn;
  logic [7:0]  vth, vrest, vleak;
  logic [3:0]  t_ref;
  logic        lat_inhibit, count_clr;
  logic [7:0]  vmem, vmem2;
  logic        out_spike, out_spike2, refractory, refractory2;
  logic [7:0]  spike_count;
  logic [1:0]  spike_count2;

  int total = 0;
  int bad = 0;
  int m_v, m_rem, m_cnt, m_cnt2;
  bit m_sp;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk(clk), .reset(reset), .spikes_in(spikes_in), .weights(weights), .ksyn(ksyn),
    .vth(vth), .vrest(vrest), .vleak(vleak), .t_ref(t_ref), .lat_inhibit(lat_inhibit),
    .count_clr(count_clr), .vmem(vmem), .out_spike(out_spike), .refractory(refractory),
    .spike_count(spike_count)
  );

  lif_neuron #(.SC_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .spikes_in(spikes_in), .weights(weights), .ksyn(ksyn),
    .vth(vth), .vrest(vrest), .vleak(vleak), .t_ref(t_ref), .lat_inhibit(lat_inhibit),
    .count_clr(count_clr), .vmem(vmem2), .out_spike(out_spike2), .refractory(refractory2),
    .spike_count(spike_count2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    int syn, vc;
    syn = 0;
    for (int i = 0; i < 25; i++) if (spikes_in[i]) syn += int'(weights[i*4 +: 4]);
    m_sp = 1'b0;
    if (!reset) begin
      m_v = int'(vrest); m_rem = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (m_rem > 0) begin
        m_rem--; m_v = int'(vrest);
      end else begin
        vc = m_v + int'(ksyn) * syn - int'(vleak);
        if (vc < int'(vrest)) vc = int'(vrest);
        if (vc > 255) vc = 255;
        if (lat_inhibit) m_v = int'(vrest);
        else if (vc >= int'(vth)) begin m_sp = 1'b1; m_v = int'(vrest); m_rem = int'(t_ref); end
        else m_v = vc;
      end
      if (count_clr) begin m_cnt = 0; m_cnt2 = 0; end
      else if (m_sp) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".vmem"}, int'(vmem), m_v);
    check({tag, ".spike"}, int'(out_spike), int'(m_sp));
    check({tag, ".refr"}, int'(refractory), int'(m_rem > 0));
    check({tag, ".cnt"}, int'(spike_count), m_cnt);
    check({tag, ".cnt2"}, int'(spike_count2), m_cnt2);
  endtask

  task automatic set_weights(input int w);
    for (int i = 0; i < 25; i++) weights[i*4 +: 4] = 4'(w);
  endtask

  initial begin
    reset = 1'b0; spikes_in = '0; weights = '0; ksyn = 5'd1; vth = 8'd40;
    vrest = 8'd10; vleak = 8'd0; t_ref = 4'd0; lat_inhibit = 1'b0; count_clr = 1'b0;
    m_v = 0; m_rem = 0; m_cnt = 0; m_cnt2 = 0; m_sp = 1'b0;
    repeat (2) step("reset");
    check("reset.vmem_const", int'(vmem), 10);
    reset = 1'b1;
    set_weights(3); spikes_in = 25'h1f;
    step("if1");
    check("if1.vmem_const", int'(vmem), 25);
    repeat (5) step("if");
    spikes_in = '0; vth = 8'd200;
    repeat (2) begin
      spikes_in = 25'h1; set_weights(12); step("charge");
    end
    spikes_in = '0; vleak = 8'd5;
    repeat (6) step("leak");
    check("leak.floor_const", int'(vmem), 10);
    vleak = 8'd0; ksyn = 5'd31; set_weights(15); spikes_in = '1; vth = 8'd255;
    repeat (3) step("sat");
    vth = 8'd254; ksyn = 5'd1; set_weights(1); spikes_in = 25'h1;
    repeat (3) step("ceil");
    spikes_in = '1; set_weights(15); ksyn = 5'd1; vth = 8'd100; t_ref = 4'd3;
    for (int i = 0; i < 20; i++) begin
      lat_inhibit = i % 3 == 1;
      step("refr");
    end
    lat_inhibit = 1'b0;
    t_ref = 4'd5; step("pre_abort");
    reset = 1'b0; step("abort");
    reset = 1'b1; t_ref = 4'd0;
    lat_inhibit = 1'b1; repeat (2) step("inhib");
    lat_inhibit = 1'b0; step("fire");
    count_clr = 1'b1; step("clr");
    count_clr = 1'b0;
    vrest = 8'd50; vth = 8'd40; spikes_in = '0;
    repeat (8) step("always");
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 49) != 0;
      spikes_in = 25'($urandom);
      for (int j = 0; j < 25; j++) weights[j*4 +: 4] = 4'($urandom);
      ksyn = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 2));
      vth = 8'($urandom_range(60, 255));
      vrest = 8'($urandom_range(0, 30));
      vleak = 8'($urandom_range(0, 40));
      t_ref = 4'($urandom_range(0, 5));
      lat_inhibit = $urandom_range(0, 9) == 0;
      count_clr = $urandom_range(0, 29) == 0;
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
